// File: rtl/xup_debounce_ch.sv
// ---------------------------------------------------------------------------
// xup_debounce_ch
//   One debounce channel. It synchronises a raw asynchronous button input,
//   qualifies every level change over DEBOUNCE_CYCLES consecutive stable
//   samples, and emits a single-cycle toggle request when a qualified change
//   is accepted.
//
//   Parameters
//     DEBOUNCE_CYCLES   stable samples needed to accept a new level (>= 2)
//     CW                counter width, computed by the parent
//     PULSE_ON_RELEASE  0: pulse on accepted rise only; 1: on rise and fall
//
//   Ports
//     clk      in  1  rising-edge clock
//     reset_n  in  1  asynchronous active-low reset
//     btn_in   in  1  raw asynchronous input, active-high
//     level    out 1  debounced level
//     t        out 1  one-cycle toggle request
// ---------------------------------------------------------------------------
module xup_debounce_ch #(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int CW               = 2,
  parameter int PULSE_ON_RELEASE = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic level,
  output logic t
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          differs;
  logic          terminal;
  logic          pulse_now;

  // Only the second sync stage feeds the qualifier.
  assign differs   = (s2 != level);
  assign terminal  = differs && (cnt == CNT_LAST);
  // A falling acceptance pulses only when release pulses are enabled.
  assign pulse_now = terminal && (s2 || (PULSE_ON_RELEASE != 0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      t     <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      t  <= pulse_now;
      if (!differs) begin
        // Any bounce back to the current level restarts qualification.
        cnt <= '0;
      end else if (terminal) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/xup_toggle_debouncer.sv
// ---------------------------------------------------------------------------
// xup_toggle_debouncer
//   Conditioning stage ahead of the toggle-flip-flop vector. Each of SIZE raw
//   button inputs is synchronised and debounced independently; a qualified
//   press produces one t pulse so the downstream q bit flips exactly once.
//
//   Parameters
//     SIZE              number of independent channels
//     DEBOUNCE_CYCLES   stable cycles needed to accept a new level (>= 2)
//     PULSE_ON_RELEASE  0: t on accepted 0->1 only; 1: on 0->1 and 1->0
//     DELAY             output delay for simulation models; this
//                       implementation registers outputs without delay
//
//   Ports
//     clk      in  1     rising-edge clock
//     reset_n  in  1     asynchronous active-low reset
//     btn_in   in  SIZE  raw asynchronous inputs, active-high
//     level    out SIZE  debounced level per channel
//     t        out SIZE  one-cycle toggle request per channel
// ---------------------------------------------------------------------------
module xup_toggle_debouncer #(
  parameter int SIZE             = 4,
  parameter int DEBOUNCE_CYCLES  = 1000000,
  parameter int PULSE_ON_RELEASE = 0,
  parameter int DELAY            = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [SIZE-1:0] btn_in,
  output logic [SIZE-1:0] level,
  output logic [SIZE-1:0] t
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, which always fits in clog2.
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("xup_toggle_debouncer: DEBOUNCE_CYCLES must be at least 2");
  end

  if (DELAY < 0) begin : g_bad_delay
    $error("xup_toggle_debouncer: DELAY must not be negative");
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_ch
    xup_debounce_ch #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .CW               (CW),
      .PULSE_ON_RELEASE (PULSE_ON_RELEASE)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_in  (btn_in[i]),
      .level   (level[i]),
      .t       (t[i])
    );
  end

endmodule
